// File: rtl/csr_wr_pipe_if.sv
// CSR write pipeline bus: EX-side request, per-stage handshake,
// and the MM1/MM2/WB write views plus commit status.
interface csr_wr_pipe_if;
  logic        ex_valid;
  logic        ex_ready_go;
  logic        ex_csr_we;
  logic [13:0] ex_csr_addr;
  logic [31:0] ex_csr_wdata;
  logic [31:0] ex_csr_wmask;
  logic        ex_soft_int_gen;
  logic        mm1_ready_go;
  logic        mm2_ready_go;
  logic        wb_ready_go;
  logic        wb_flush;

  logic        mm1_valid;
  logic        mm1_csr_we;
  logic [13:0] mm1_csr_addr;
  logic [31:0] mm1_csr_wdata;
  logic [31:0] mm1_csr_wmask;
  logic        mm2_valid;
  logic        mm2_csr_we;
  logic [13:0] mm2_csr_addr;
  logic [31:0] mm2_csr_wdata;
  logic [31:0] mm2_csr_wmask;
  logic        wb_valid;
  logic        wb_csr_we;
  logic [13:0] wb_csr_addr;
  logic [31:0] wb_csr_wdata;
  logic [31:0] wb_csr_wmask;
  logic        ex_allowin;
  logic        wb_soft_int;
  logic        csr_commit;
  logic [1:0]  csr_wr_inflight;

  modport master (
    output ex_valid, ex_ready_go, ex_csr_we, ex_csr_addr,
    output ex_csr_wdata, ex_csr_wmask, ex_soft_int_gen,
    output mm1_ready_go, mm2_ready_go, wb_ready_go, wb_flush,
    input  mm1_valid, mm1_csr_we, mm1_csr_addr,
    input  mm1_csr_wdata, mm1_csr_wmask,
    input  mm2_valid, mm2_csr_we, mm2_csr_addr,
    input  mm2_csr_wdata, mm2_csr_wmask,
    input  wb_valid, wb_csr_we, wb_csr_addr,
    input  wb_csr_wdata, wb_csr_wmask,
    input  ex_allowin, wb_soft_int, csr_commit, csr_wr_inflight
  );

  modport slave (
    input  ex_valid, ex_ready_go, ex_csr_we, ex_csr_addr,
    input  ex_csr_wdata, ex_csr_wmask, ex_soft_int_gen,
    input  mm1_ready_go, mm2_ready_go, wb_ready_go, wb_flush,
    output mm1_valid, mm1_csr_we, mm1_csr_addr,
    output mm1_csr_wdata, mm1_csr_wmask,
    output mm2_valid, mm2_csr_we, mm2_csr_addr,
    output mm2_csr_wdata, mm2_csr_wmask,
    output wb_valid, wb_csr_we, wb_csr_addr,
    output wb_csr_wdata, wb_csr_wmask,
    output ex_allowin, wb_soft_int, csr_commit, csr_wr_inflight
  );
endinterface

// File: rtl/csr_wr_pipe.sv
// CSR write carry pipeline EX->MM1->MM2->WB with valid/allowin
// handshake, WB flush, commit pulse and in-flight write count.
module csr_wr_pipe (
  input  logic         clk,
  input  logic         resetn,
  csr_wr_pipe_if.slave bus
);
  typedef struct packed {
    logic        v;
    logic        we;
    logic [13:0] addr;
    logic [31:0] wdata;
    logic [31:0] wmask;
    logic        si;
  } stg_t;

  stg_t       mm1_q, mm2_q, wb_q;
  stg_t       mm1_d, mm2_d, wb_d;
  logic [1:0] infl_q, infl_d;
  logic       wb_allowin, mm2_allowin, mm1_allowin;
  logic       ex_go, mm1_go, mm2_go;

  assign wb_allowin  = !wb_q.v | bus.wb_ready_go;
  assign mm2_allowin = !mm2_q.v | (bus.mm2_ready_go & wb_allowin);
  assign mm1_allowin = !mm1_q.v | (bus.mm1_ready_go & mm2_allowin);

  assign ex_go  = bus.ex_valid & bus.ex_ready_go;
  assign mm1_go = mm1_q.v & bus.mm1_ready_go;
  assign mm2_go = mm2_q.v & bus.mm2_ready_go;

  always_comb begin
    mm1_d = mm1_q;
    mm2_d = mm2_q;
    wb_d  = wb_q;
    if (mm1_allowin) begin
      mm1_d.v = ex_go;
      if (ex_go) begin
        mm1_d.we    = bus.ex_csr_we;
        mm1_d.addr  = bus.ex_csr_addr;
        mm1_d.wdata = bus.ex_csr_wdata;
        mm1_d.wmask = bus.ex_csr_wmask;
        mm1_d.si    = bus.ex_soft_int_gen;
      end
    end
    if (mm2_allowin) begin
      mm2_d.v = mm1_go;
      if (mm1_go) begin
        mm2_d = mm1_q;
      end
    end
    if (wb_allowin) begin
      wb_d.v = mm2_go;
      if (mm2_go) begin
        wb_d = mm2_q;
      end
    end
    // Flush beats every advance: kill valids, keep payloads untouched
    if (bus.wb_flush) begin
      mm1_d   = mm1_q;
      mm2_d   = mm2_q;
      wb_d    = wb_q;
      mm1_d.v = 1'b0;
      mm2_d.v = 1'b0;
      wb_d.v  = 1'b0;
    end
    infl_d = {1'b0, mm1_d.v & mm1_d.we}
           + {1'b0, mm2_d.v & mm2_d.we}
           + {1'b0, wb_d.v & wb_d.we};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mm1_q  <= '0;
      mm2_q  <= '0;
      wb_q   <= '0;
      infl_q <= 2'd0;
    end else begin
      mm1_q  <= mm1_d;
      mm2_q  <= mm2_d;
      wb_q   <= wb_d;
      infl_q <= infl_d;
    end
  end

  assign bus.ex_allowin = mm1_allowin;

  assign bus.mm1_valid     = mm1_q.v;
  assign bus.mm1_csr_we    = mm1_q.v & mm1_q.we;
  assign bus.mm1_csr_addr  = mm1_q.addr;
  assign bus.mm1_csr_wdata = mm1_q.wdata;
  assign bus.mm1_csr_wmask = mm1_q.wmask;

  assign bus.mm2_valid     = mm2_q.v;
  assign bus.mm2_csr_we    = mm2_q.v & mm2_q.we;
  assign bus.mm2_csr_addr  = mm2_q.addr;
  assign bus.mm2_csr_wdata = mm2_q.wdata;
  assign bus.mm2_csr_wmask = mm2_q.wmask;

  assign bus.wb_valid      = wb_q.v;
  assign bus.wb_csr_we     = wb_q.v & wb_q.we & !bus.wb_flush;
  assign bus.wb_csr_addr   = wb_q.addr;
  assign bus.wb_csr_wdata  = wb_q.wdata;
  assign bus.wb_csr_wmask  = wb_q.wmask;

  assign bus.csr_commit  = wb_q.v & bus.wb_ready_go & wb_q.we
                         & !bus.wb_flush;
  assign bus.wb_soft_int = wb_q.v & wb_q.si & !bus.wb_flush;

  assign bus.csr_wr_inflight = infl_q;
endmodule

// File: tb/tb_csr_wr_pipe.sv
// Directed bench for csr_wr_pipe: streaming, back-pressure, flush,
// soft interrupt, bubble, full-rate advance and mid-stream reset.
module tb_csr_wr_pipe;
  logic clk;
  logic resetn;
  int   vectors;
  int   miscompares;

  csr_wr_pipe_if bus ();

  csr_wr_pipe dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [13:0] a,
                       input logic [31:0] d, input logic [31:0] m,
                       input logic si);
    bus.ex_valid        = 1'b1;
    bus.ex_csr_we       = we;
    bus.ex_csr_addr     = a;
    bus.ex_csr_wdata    = d;
    bus.ex_csr_wmask    = m;
    bus.ex_soft_int_gen = si;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    resetn = 1'b0;
    bus.ex_valid = 0; bus.ex_ready_go = 1;
    bus.ex_csr_we = 0; bus.ex_csr_addr = 0;
    bus.ex_csr_wdata = 0; bus.ex_csr_wmask = 0;
    bus.ex_soft_int_gen = 0;
    bus.mm1_ready_go = 1; bus.mm2_ready_go = 1;
    bus.wb_ready_go = 1; bus.wb_flush = 0;
    #2;
    chk("rst_mm1_valid", 32'(bus.mm1_valid), 0);
    chk("rst_wb_valid", 32'(bus.wb_valid), 0);
    chk("rst_allowin", 32'(bus.ex_allowin), 1);
    chk("rst_inflight", 32'(bus.csr_wr_inflight), 0);
    chk("rst_commit", 32'(bus.csr_commit), 0);
    chk("rst_soft", 32'(bus.wb_soft_int), 0);
    tick();
    resetn = 1'b1;

    // streaming
    issue(1, 14'h004, 32'h1, 32'h3, 0);
    tick();
    bus.ex_valid = 0;
    chk("s1_mm1_we", 32'(bus.mm1_csr_we), 1);
    chk("s1_mm1_addr", 32'(bus.mm1_csr_addr), 32'h4);
    chk("s1_mm2_valid", 32'(bus.mm2_valid), 0);
    chk("s1_inflight", 32'(bus.csr_wr_inflight), 1);
    tick();
    chk("s2_mm2_we", 32'(bus.mm2_csr_we), 1);
    chk("s2_mm1_valid", 32'(bus.mm1_valid), 0);
    chk("s2_commit", 32'(bus.csr_commit), 0);
    tick();
    chk("s3_wb_we", 32'(bus.wb_csr_we), 1);
    chk("s3_commit", 32'(bus.csr_commit), 1);
    chk("s3_wb_wdata", bus.wb_csr_wdata, 32'h1);
    chk("s3_wb_wmask", bus.wb_csr_wmask, 32'h3);
    chk("s3_inflight", 32'(bus.csr_wr_inflight), 1);
    tick();
    chk("s4_commit", 32'(bus.csr_commit), 0);
    chk("s4_wb_valid", 32'(bus.wb_valid), 0);
    chk("s4_inflight", 32'(bus.csr_wr_inflight), 0);
    chk("s4_wb_addr_held", 32'(bus.wb_csr_addr), 32'h4);

    // back-pressure
    bus.wb_ready_go = 0;
    issue(1, 14'h010, 32'hA0, 32'hF, 0);
    tick();
    issue(1, 14'h011, 32'hB0, 32'hF, 0);
    tick();
    issue(1, 14'h012, 32'hC0, 32'hF, 0);
    tick();
    issue(1, 14'h013, 32'hD0, 32'hF, 0);
    chk("bp_allowin", 32'(bus.ex_allowin), 0);
    tick();
    chk("bp_inflight", 32'(bus.csr_wr_inflight), 3);
    chk("bp_wb_addr", 32'(bus.wb_csr_addr), 32'h10);
    chk("bp_mm2_addr", 32'(bus.mm2_csr_addr), 32'h11);
    chk("bp_mm1_addr", 32'(bus.mm1_csr_addr), 32'h12);
    chk("bp_mm1_wdata", bus.mm1_csr_wdata, 32'hC0);
    chk("bp_commit", 32'(bus.csr_commit), 0);

    // flush with all three valid, EX still requesting
    bus.wb_ready_go = 1;
    bus.wb_flush = 1;
    #1;
    chk("fl_wb_we", 32'(bus.wb_csr_we), 0);
    chk("fl_commit", 32'(bus.csr_commit), 0);
    tick();
    bus.wb_flush = 0;
    bus.ex_valid = 0;
    chk("fl_mm1_valid", 32'(bus.mm1_valid), 0);
    chk("fl_mm2_valid", 32'(bus.mm2_valid), 0);
    chk("fl_wb_valid", 32'(bus.wb_valid), 0);
    chk("fl_inflight", 32'(bus.csr_wr_inflight), 0);
    chk("fl_mm1_addr_kept", 32'(bus.mm1_csr_addr), 32'h12);

    // soft interrupt on a non-writing instruction
    issue(0, 14'h020, 32'h0, 32'h0, 1);
    tick();
    bus.ex_valid = 0;
    bus.ex_soft_int_gen = 0;
    chk("si1_soft", 32'(bus.wb_soft_int), 0);
    chk("si1_mm1_we", 32'(bus.mm1_csr_we), 0);
    tick();
    chk("si2_soft", 32'(bus.wb_soft_int), 0);
    tick();
    chk("si3_soft", 32'(bus.wb_soft_int), 1);
    chk("si3_commit", 32'(bus.csr_commit), 0);
    chk("si3_inflight", 32'(bus.csr_wr_inflight), 0);
    tick();
    chk("si4_soft", 32'(bus.wb_soft_int), 0);

    // bubble: MM1 holds two cycles while EX keeps requesting
    bus.mm1_ready_go = 0;
    issue(1, 14'h030, 32'hDEADBEEF, 32'hFFFF, 0);
    tick();
    issue(1, 14'h031, 32'h11111111, 32'h1, 0);
    tick();
    chk("bb1_mm2_valid", 32'(bus.mm2_valid), 0);
    chk("bb1_mm1_addr", 32'(bus.mm1_csr_addr), 32'h30);
    tick();
    chk("bb2_mm2_valid", 32'(bus.mm2_valid), 0);
    chk("bb2_mm1_wdata", bus.mm1_csr_wdata, 32'hDEADBEEF);
    bus.mm1_ready_go = 1;
    bus.ex_valid = 0;
    tick();
    chk("bb3_mm2_addr", 32'(bus.mm2_csr_addr), 32'h30);
    chk("bb3_mm2_we", 32'(bus.mm2_csr_we), 1);
    chk("bb3_mm1_valid", 32'(bus.mm1_valid), 0);
    tick();
    tick();

    // full-rate streaming with no bubble
    issue(1, 14'h040, 32'h40, 32'h1, 0);
    tick();
    issue(1, 14'h041, 32'h41, 32'h1, 0);
    tick();
    issue(1, 14'h042, 32'h42, 32'h1, 0);
    tick();
    issue(1, 14'h043, 32'h43, 32'h1, 0);
    chk("fr_commit0", 32'(bus.csr_commit), 1);
    chk("fr_inflight", 32'(bus.csr_wr_inflight), 3);
    chk("fr_allowin", 32'(bus.ex_allowin), 1);
    tick();
    bus.ex_valid = 0;
    chk("fr_wb_addr", 32'(bus.wb_csr_addr), 32'h41);
    chk("fr_mm2_addr", 32'(bus.mm2_csr_addr), 32'h42);
    chk("fr_mm1_addr", 32'(bus.mm1_csr_addr), 32'h43);
    chk("fr_commit1", 32'(bus.csr_commit), 1);
    tick();
    tick();
    tick();

    // reset asserted between edges with two valid stages
    issue(1, 14'h050, 32'h50, 32'h1, 0);
    tick();
    issue(1, 14'h051, 32'h51, 32'h1, 0);
    tick();
    chk("mr_pre_inflight", 32'(bus.csr_wr_inflight), 2);
    #2;
    resetn = 0;
    #1;
    chk("mr_mm1_valid", 32'(bus.mm1_valid), 0);
    chk("mr_mm2_valid", 32'(bus.mm2_valid), 0);
    chk("mr_inflight", 32'(bus.csr_wr_inflight), 0);
    chk("mr_allowin", 32'(bus.ex_allowin), 1);
    chk("mr_mm1_addr", 32'(bus.mm1_csr_addr), 0);
    tick();
    chk("mr_hold_valid", 32'(bus.mm1_valid), 0);
    resetn = 1;
    tick();
    bus.ex_valid = 0;
    chk("mr_rel_mm1_valid", 32'(bus.mm1_valid), 1);
    chk("mr_rel_mm1_addr", 32'(bus.mm1_csr_addr), 32'h51);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/csr_wr_pipe.md
CSR_WR_PIPE -- requirements
Module: csr_wr_pipe

Interface
REQ-001 SHALL have a single clock and an asynchronous, active-low reset: clk  in  1  rising-edge clock; resetn  in  1  asynchronous active-low reset.
REQ-002 SHALL take the EX handshake and write inputs: ex_valid  in  1; ex_ready_go  in  1; ex_csr_we  in  1; ex_csr_addr  in  14; ex_csr_wdata  in  32; ex_csr_wmask  in  32; ex_soft_int_gen  in  1  EX soft-interrupt request.
REQ-003 SHALL take the later-stage handshake inputs: mm1_ready_go, mm2_ready_go, wb_ready_go  in  1 each; wb_flush  in  1  exception/ertn taken at WB.
REQ-004 SHALL provide one output set per stage X in {mm1, mm2, wb}: X_valid  out  1; X_csr_we  out  1; X_csr_addr  out  14; X_csr_wdata  out  32; X_csr_wmask  out  32.
REQ-005 SHALL provide the status outputs: ex_allowin  out  1; wb_soft_int  out  1; csr_commit  out  1; csr_wr_inflight  out  2  count of valid CSR writes in MM1..WB.

Function
REQ-006 SHALL compute allowin combinationally: wb_allowin = !wb_valid | wb_ready_go; mm2_allowin = !mm2_valid | (mm2_ready_go & wb_allowin); mm1_allowin = !mm1_valid | (mm1_ready_go & mm2_allowin); ex_allowin = mm1_allowin.
REQ-007 SHALL load MM1 from EX on clk when ex_valid & ex_ready_go & mm1_allowin, capturing we/addr/wdata/wmask and ex_soft_int_gen.
REQ-008 SHALL set mm1_valid <= ex_valid & ex_ready_go whenever mm1_allowin; it SHALL hold when mm1_allowin is 0.
REQ-009 SHALL apply the same rule MM1->MM2 and MM2->WB, each with its own ready_go and allowin, moving the payload and the soft-int bit unchanged.
REQ-010 SHALL hold a stage's payload registers when that stage does not load; payload SHALL NOT be cleared when a stage drains.
REQ-011 SHALL gate X_csr_we = X_valid & stored_we for all three stages; addr, wdata and wmask SHALL be the raw register values.
REQ-012 SHALL clear mm1_valid, mm2_valid and wb_valid at the next edge on wb_flush=1 and SHALL suppress the EX->MM1 load in that cycle; flush SHALL take priority over every advance.
REQ-013 SHALL force wb_csr_we=0 and csr_commit=0 combinationally in the cycle wb_flush=1.
REQ-014 SHALL drive csr_commit = wb_valid & wb_ready_go & stored_we & !wb_flush, as a single pulse per retiring instruction.
REQ-015 SHALL drive wb_soft_int = wb_valid & stored_soft_int & !wb_flush.
REQ-016 SHALL register csr_wr_inflight as the sum of mm1_csr_we, mm2_csr_we and wb_csr_we; it SHALL be updated each edge from the next-state valid/we values.
REQ-017 SHALL keep csr_wr_inflight at most 3; the width is 2 bits and no wrap is possible.
REQ-018 SHALL, on simultaneous drain of WB and load of MM1 at full occupancy with all ready_go=1, advance every stage in the same edge with no bubble.
REQ-019 SHALL have zero added latency: an instruction with all ready_go=1 reaches WB exactly 3 edges after leaving EX.

Reset
REQ-020 SHALL clear, while resetn=0 and asynchronously: all valid bits, stored we, stored soft_int, all addr/wdata/wmask registers (to 0) and csr_wr_inflight (to 0).
REQ-021 SHALL hold all outputs during reset at: X_valid=0, X_csr_we=0, csr_commit=0, wb_soft_int=0; ex_allowin=1 (combinational from valid=0).
REQ-022 SHALL, if reset asserts mid-operation, discard all in-flight instructions; the first load after release SHALL occur no earlier than the first rising edge with resetn=1.

Verification
REQ-023 SHALL cover streaming: EX writes addr=0x004, wdata=0x1, wmask=0x3, all ready_go=1 -> mm1_csr_we at edge 1, mm2 at edge 2, wb at edge 3, csr_commit=1 for one cycle.
REQ-024 SHALL cover back-pressure: wb_ready_go=0 with 3 CSR writes issued back-to-back -> pipeline fills, ex_allowin=0, csr_wr_inflight=3, no payload overwritten.
REQ-025 SHALL cover flush: wb_flush=1 with MM1/MM2/WB all valid -> wb_csr_we=0 and csr_commit=0 in the same cycle, all valid=0 next cycle, csr_wr_inflight=0, no EX load that cycle.
REQ-026 SHALL cover soft interrupt: ex_soft_int_gen=1 on one instruction -> wb_soft_int=1 exactly when that instruction is valid in WB, 0 otherwise.
REQ-027 SHALL cover reset mid-stream: resetn=0 asserted between edges with 2 valid stages -> all valid=0 immediately, csr_wr_inflight=0, ex_allowin=1.
REQ-028 SHALL cover a bubble: mm1_ready_go=0 for 2 cycles -> MM2 receives no instruction, mm2_valid=0, and the held MM1 payload is unchanged.
